// File: rtl/lc3_pkg.sv
// Shared LC3 front-end constants: stage indices, next-PC select codes
// and the default reset PC.
package lc3_pkg;

    localparam logic [1:0] STAGE_FETCH     = 2'd0;
    localparam logic [1:0] STAGE_DECODE    = 2'd1;
    localparam logic [1:0] STAGE_EXECUTE   = 2'd2;
    localparam logic [1:0] STAGE_WRITEBACK = 2'd3;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_HOLD = 2'b01;
    localparam logic [1:0] PC_EA   = 2'b10;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h3000;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: PC+1, hold or EA.
// Shared between the fetch sequencer and the branch unit.
module pc_next_mux
    import lc3_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [15:0] ea,
    input  logic [1:0]  pc_control,
    output logic [15:0] next_pc
);

    always_comb begin
        next_pc = pc;
        case (pc_control)
            PC_INC:  next_pc = pc + 16'd1;
            PC_HOLD: next_pc = pc;
            PC_EA:   next_pc = ea;
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// LC3 fetch sequencer: stage counter, IR and PC with a memory fetch stall.
// Optional counters built with FETCH_SEQUENCER_RETIRE_COUNT_EN.
module fetch_sequencer
    import lc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          LAST_STAGE = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] MEM_DATA,
    input  logic        MEM_READY,
    input  logic        IR_LE,
    input  logic        PC_LE,
    input  logic [1:0]  PC_CONTROL,
    input  logic [15:0] EA,
    input  logic        NEXT_STAGE_LE,
    input  logic [1:0]  NEXT_STAGE,
    output logic [1:0]  STAGE,
    output logic [15:0] INSTRUCTION,
    output logic [15:0] PC,
    output logic        FETCH_REQ,
    output logic [15:0] FETCH_ADDR
`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
    ,
    output logic [31:0] RETIRE_COUNT,
    output logic [31:0] STALL_CYCLES
`endif
);

    localparam logic [1:0] LAST = 2'(LAST_STAGE);

    logic [1:0]  stage_q, stage_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] next_pc;
    logic        in_fetch;
    logic        stall;

    assign in_fetch = (stage_q == STAGE_FETCH);
    assign stall    = in_fetch && !MEM_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stage_q <= STAGE_FETCH;
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (!stall) begin
            if (NEXT_STAGE_LE) begin
                stage_d = NEXT_STAGE;
            end else if (stage_q == LAST) begin
                stage_d = STAGE_FETCH;
            end else begin
                stage_d = stage_q + 2'd1;
            end
        end
    end

    always_comb begin
        STAGE     = stage_q;
        FETCH_REQ = in_fetch && !RESET;
    end

    pc_next_mux u_pc_next_mux (
        .pc         (pc_q),
        .ea         (EA),
        .pc_control (PC_CONTROL),
        .next_pc    (next_pc)
    );

    // IR only loads while fetching, so it stays stable for stages 1..LAST.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        if (!stall) begin
            if (PC_LE) begin
                pc_d = next_pc;
            end
            if (IR_LE && in_fetch) begin
                ir_d = MEM_DATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= RESET_PC;
            ir_q <= 16'h0000;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign PC          = pc_q;
    assign FETCH_ADDR  = pc_q;
    assign INSTRUCTION = ir_q;

`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
    logic [31:0] retire_q, retire_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        retire;

    assign retire = !stall && (stage_q == LAST) && (stage_d == STAGE_FETCH);

    always_comb begin
        retire_d    = retire ? retire_q + 32'd1 : retire_q;
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            retire_q    <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            retire_q    <= retire_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign RETIRE_COUNT = retire_q;
    assign STALL_CYCLES = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a stage/PC/IR reference model.
// Counter outputs are checked when FETCH_SEQUENCER_RETIRE_COUNT_EN is defined.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        ir_le;
    logic        pc_le;
    logic [1:0]  pc_ctl;
    logic [15:0] ea;
    logic        ns_le;
    logic [1:0]  ns;
    logic [1:0]  stage;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        freq;
    logic [15:0] faddr;
`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
    logic [31:0] retire_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    int  m_stage;
    int  m_pc;
    int  m_ir;
    int  m_ret;
    int  m_stl;
    bit  m_valid = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .CLK           (clk),
        .RESET         (rst),
        .MEM_DATA      (mem_data),
        .MEM_READY     (mem_ready),
        .IR_LE         (ir_le),
        .PC_LE         (pc_le),
        .PC_CONTROL    (pc_ctl),
        .EA            (ea),
        .NEXT_STAGE_LE (ns_le),
        .NEXT_STAGE    (ns),
        .STAGE         (stage),
        .INSTRUCTION   (instr),
        .PC            (pc),
        .FETCH_REQ     (freq),
        .FETCH_ADDR    (faddr)
`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
        ,
        .RETIRE_COUNT  (retire_cnt),
        .STALL_CYCLES  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic void model_step();
        int nxt;
        if (rst) begin
            m_stage = 0;
            m_pc    = 'h3000;
            m_ir    = 0;
            m_ret   = 0;
            m_stl   = 0;
            m_valid = 1;
        end else if (m_stage == 0 && !mem_ready) begin
            m_stl++;
        end else begin
            if (ir_le && m_stage == 0) m_ir = int'(mem_data);
            if (pc_le) begin
                if (pc_ctl == 2'b00) m_pc = (m_pc + 1) % 65536;
                else if (pc_ctl == 2'b10) m_pc = int'(ea);
            end
            nxt = ns_le ? int'(ns) : (m_stage + 1) % 4;
            if (m_stage == 3 && nxt == 0) m_ret++;
            m_stage = nxt;
        end
    endfunction

    // Called at a negedge: drive, check comb outputs, clock, check state.
    task automatic drive(input logic r, input logic rdy, input logic [15:0] d,
                         input logic irl, input logic pcl, input logic [1:0] c,
                         input logic [15:0] e, input logic nsl,
                         input logic [1:0] n);
        rst = r; mem_ready = rdy; mem_data = d; ir_le = irl;
        pc_le = pcl; pc_ctl = c; ea = e; ns_le = nsl; ns = n;
        #1;
        if (m_valid) begin
            chk("fetch_req", 32'(freq), 32'((m_stage == 0) && !r));
            chk("fetch_addr", 32'(faddr), m_pc);
        end else begin
            chk("fetch_req_rst", 32'(freq), 32'(!r));
        end
        model_step();
        @(posedge clk);
        #1;
        chk("stage", 32'(stage), m_stage);
        chk("pc", 32'(pc), m_pc);
        chk("instr", 32'(instr), m_ir);
`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
        chk("retire", retire_cnt, m_ret);
        chk("stalls", stall_cnt, m_stl);
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1, 0, 16'h0, 0, 0, 2'b00, 16'h0, 0, 2'd0);
    endtask

    initial begin
        rst = 1; mem_ready = 0; mem_data = 0; ir_le = 0; pc_le = 0;
        pc_ctl = 0; ea = 0; ns_le = 0; ns = 0;
        @(negedge clk);
        do_reset();
        chk("rst_stage", 32'(stage), 0);
        chk("rst_pc", 32'(pc), 32'h3000);
        chk("rst_instr", 32'(instr), 0);

        // zero-wait instruction: latch IR and bump PC in FETCH only
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 16'h1042, m_stage == 0, m_stage == 0,
                  2'b00, 16'h0, 0, 2'd0);
            if (i == 0) chk("ir_from_s1", 32'(instr), 32'h1042);
        end
        chk("seq_stage", 32'(stage), 0);
        chk("seq_pc", 32'(pc), 32'h3001);

        // memory stall in FETCH, then ready
        for (int i = 0; i < 3; i++)
            drive(0, 0, 16'h5555, 1, 1, 2'b00, 16'h0, 0, 2'd0);
        chk("stall_stage", 32'(stage), 0);
        chk("stall_pc", 32'(pc), 32'h3001);
        drive(0, 1, 16'h2222, 1, 0, 2'b00, 16'h0, 0, 2'd0);
        chk("stall_release", 32'(stage), 1);

        // EA load, then wrap from FFFF
        drive(0, 1, 16'h0, 0, 1, 2'b10, 16'h4000, 0, 2'd0);
        chk("pc_ea", 32'(pc), 32'h4000);
        drive(0, 1, 16'h0, 0, 1, 2'b10, 16'hFFFF, 0, 2'd0);
        drive(0, 1, 16'h0, 0, 1, 2'b00, 16'h0, 0, 2'd0);
        chk("pc_wrap", 32'(pc), 0);

        // stage override: hold in EXECUTE, then jump back to FETCH
        while (m_stage != 2) drive(0, 1, 16'h0, 0, 0, 2'b00, 16'h0, 0, 2'd0);
        drive(0, 1, 16'h0, 0, 0, 2'b00, 16'h0, 1, 2'd2);
        drive(0, 1, 16'h0, 0, 0, 2'b00, 16'h0, 1, 2'd2);
        chk("hold_s2", 32'(stage), 2);
        while (m_stage != 1) drive(0, 1, 16'h0, 0, 0, 2'b00, 16'h0, 0, 2'd0);
        drive(0, 1, 16'h0, 0, 0, 2'b00, 16'h0, 1, 2'd0);
        chk("ns_to_0", 32'(stage), 0);

        // reset mid-fetch with ready memory
        do_reset();
        drive(1, 1, 16'hBEEF, 1, 1, 2'b00, 16'h0, 0, 2'd0);
        chk("rst_fetch_ir", 32'(instr), 0);
        chk("rst_fetch_pc", 32'(pc), 32'h3000);

`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
        // three instructions with two stall cycles in front of the second
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                drive(0, 0, 16'h0, 1, 1, 2'b00, 16'h0, 0, 2'd0);
                drive(0, 0, 16'h0, 1, 1, 2'b00, 16'h0, 0, 2'd0);
            end
            for (int i = 0; i < 4; i++)
                drive(0, 1, 16'h1000, m_stage == 0, m_stage == 0,
                      2'b00, 16'h0, 0, 2'd0);
        end
        chk("retire3", retire_cnt, 3);
        chk("stall2", stall_cnt, 2);
`endif

        // randomized decoder/memory behaviour
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 65),
                  16'($urandom),
                  1'($urandom),
                  1'($urandom),
                  2'($urandom),
                  16'($urandom),
                  ($urandom_range(0, 99) < 20),
                  2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream neighbour of the LC3 control decoder.
- Owns the STAGE counter, the instruction register (drives INSTRUCTION) and the PC register.
- Issues instruction-fetch requests to memory and stalls stage 0 until memory answers.
- Consumes the decoder's NEXT_STAGE_LE/NEXT_STAGE, IR_LE, PC_LE and PC_CONTROL to sequence execution.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.
- LAST_STAGE, 3, highest stage index; the default increment wraps to 0 after it.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- MEM_DATA  input  16  instruction word returned by memory.
- MEM_READY  input  1  MEM_DATA valid this cycle for the outstanding fetch.
- IR_LE  input  1  decoder request to latch IR.
- PC_LE  input  1  decoder request to update PC.
- PC_CONTROL  input  2  next-PC select: 00 PC+1, 01 hold, 10 EA, 11 hold (reserved).
- EA  input  16  effective address from the EA unit.
- NEXT_STAGE_LE  input  1  decoder override of the default stage advance.
- NEXT_STAGE  input  2  override target stage.
- STAGE  output  2  current stage, to the decoder.
- INSTRUCTION  output  16  IR contents, to the decoder.
- PC  output  16  current PC.
- FETCH_REQ  output  1  fetch request to memory.
- FETCH_ADDR  output  16  fetch address; equals PC.

Behaviour:
- Clock and reset: one clock (CLK); synchronous, active-high reset (RESET).
- Reset values: STAGE=0, PC=RESET_PC, INSTRUCTION=16'h0000, FETCH_REQ=0.
- Stages: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK.
- FETCH_REQ = (STAGE==0) && !RESET. FETCH_ADDR = PC, combinational.
- stall = (STAGE==0) && !MEM_READY. While stall:
  - STAGE, PC and INSTRUCTION hold.
  - IR_LE, PC_LE and NEXT_STAGE_LE are ignored (stall wins).
- When not stalled, each rising edge:
  - Stage: if NEXT_STAGE_LE, STAGE <= NEXT_STAGE. Otherwise STAGE <= (STAGE==LAST_STAGE) ? 0 : STAGE+1.
  - IR: if IR_LE && STAGE==0, INSTRUCTION <= MEM_DATA. IR_LE in stages 1-3 is ignored; the IR only changes in FETCH.
  - PC: if PC_LE, PC <= next_pc. next_pc is PC+1 (mod 2^16, so 16'hFFFF wraps to 0), PC (01/11) or EA (10).
- Latency:
  - Fetch completes in the first cycle with MEM_READY in stage 0.
  - Zero-wait memory gives one instruction per LAST_STAGE+1 cycles.
  - INSTRUCTION is valid to the decoder from stage 1.
- MEM_READY outside stage 0 is ignored and does not advance anything.
- NEXT_STAGE_LE with NEXT_STAGE==STAGE: the block holds in that stage (used for multi-cycle ops). NEXT_STAGE greater than LAST_STAGE is taken as-is.
- Simultaneous events:
  - PC_LE and IR_LE in the same FETCH cycle: IR captures MEM_DATA fetched at the old PC; PC updates the same edge.
  - RESET has priority over every input.
- RESET mid-fetch: the outstanding fetch is abandoned. FETCH_REQ drops in the reset cycle. Any MEM_READY in that cycle is ignored, and a fresh fetch at RESET_PC starts the cycle after reset deasserts.

Optional Feature:
- Macro: FETCH_SEQUENCER_RETIRE_COUNT_EN.
- Defined:
  - Adds output RETIRE_COUNT[31:0], reset to 0.
  - Increments by 1 (wrapping) on every non-stalled edge leaving stage LAST_STAGE by default advance or by NEXT_STAGE_LE to 0.
  - Also adds output STALL_CYCLES[31:0], reset to 0, incrementing on every stall cycle.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package lc3_pkg holds:
  - stage constants STAGE_FETCH=0, STAGE_DECODE=1, STAGE_EXECUTE=2, STAGE_WRITEBACK=3;
  - PC_CONTROL encodings PC_INC=2'b00, PC_HOLD=2'b01, PC_EA=2'b10;
  - RESET_PC default 16'h3000.
- One sub-module, pc_next_mux: combinational next_pc from PC, EA and PC_CONTROL. It is shared with the later branch unit.

Test Plan:
- Reset then MEM_READY held 1, MEM_DATA=16'h1042, IR_LE=1 in stage 0, PC_LE=1 with PC_CONTROL=00 in stage 0 only -> STAGE 0,1,2,3,0; INSTRUCTION=16'h1042 from stage 1; PC 3000->3001; FETCH_ADDR=3000 then 3001.
- MEM_READY low for 3 cycles in stage 0 -> STAGE stays 0, FETCH_REQ=1, PC/IR unchanged; advances in the cycle MEM_READY rises.
- PC_CONTROL=10, EA=16'h4000, PC_LE=1 -> PC=16'h4000; PC=16'hFFFF with PC_CONTROL=00 -> PC=16'h0000.
- NEXT_STAGE_LE=1, NEXT_STAGE=0 in stage 1 -> STAGE=0 next cycle; NEXT_STAGE=2 in stage 2 for 2 cycles -> stays 2.
- RESET asserted during stage 0 with MEM_READY=1 -> FETCH_REQ=0, INSTRUCTION unchanged at 0, PC=16'h3000 next cycle.
- With FETCH_SEQUENCER_RETIRE_COUNT_EN: 3 zero-wait instructions plus 2 stall cycles -> RETIRE_COUNT=3, STALL_CYCLES=2.
